// File: rtl/ram_resp_adapter.sv
// Valid/ready channel front-end for a 1R1W RAM with 1-cycle read latency.
// Optional RAM_RESP_ADAPTER_RD_MASK_ZERO_EN zeroes read partitions whose mask bit was clear.
module ram_resp_adapter #(
    parameter int DATA_WIDTH     = 64,
    parameter int SIZE           = 1024,
    parameter int ADDR_WIDTH     = $clog2(SIZE),
    parameter int NUM_PARTITIONS = 64
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [ADDR_WIDTH+NUM_PARTITIONS-1:0]           rd_req_r_data,
    input  logic                                           rd_req_r_vld,
    output logic                                           rd_req_r_rdy,
    output logic [DATA_WIDTH-1:0]                          rd_resp_s_data,
    output logic                                           rd_resp_s_vld,
    input  logic                                           rd_resp_s_rdy,
    input  logic [ADDR_WIDTH+DATA_WIDTH+NUM_PARTITIONS-1:0] wr_req_r_data,
    input  logic                                           wr_req_r_vld,
    output logic                                           wr_req_r_rdy,
    output logic                                           wr_resp_s_vld,
    input  logic                                           wr_resp_s_rdy,
    output logic [ADDR_WIDTH-1:0]                          ram_rd_addr,
    output logic [NUM_PARTITIONS-1:0]                      ram_rd_mask,
    output logic                                           ram_rd_en,
    input  logic [DATA_WIDTH-1:0]                          ram_rd_data,
    output logic [ADDR_WIDTH-1:0]                          ram_wr_addr,
    output logic [DATA_WIDTH-1:0]                          ram_wr_data,
    output logic [NUM_PARTITIONS-1:0]                      ram_wr_mask,
    output logic                                           ram_wr_en
);

    localparam int PW       = DATA_WIDTH / NUM_PARTITIONS;
    localparam int RD_DEPTH = 3;

    logic [ADDR_WIDTH-1:0]     rd_addr;
    logic [NUM_PARTITIONS-1:0] rd_mask;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic [NUM_PARTITIONS-1:0] wr_mask;

    assign rd_addr = rd_req_r_data[ADDR_WIDTH+NUM_PARTITIONS-1:NUM_PARTITIONS];
    assign rd_mask = rd_req_r_data[NUM_PARTITIONS-1:0];
    assign wr_addr = wr_req_r_data[ADDR_WIDTH+DATA_WIDTH+NUM_PARTITIONS-1:DATA_WIDTH+NUM_PARTITIONS];
    assign wr_data = wr_req_r_data[DATA_WIDTH+NUM_PARTITIONS-1:NUM_PARTITIONS];
    assign wr_mask = wr_req_r_data[NUM_PARTITIONS-1:0];

    logic                  inflight_q, inflight_d;
    logic [1:0]            rd_cnt_q, rd_cnt_d;
    logic [1:0]            rd_head_q, rd_head_d;
    logic [1:0]            rd_tail_q, rd_tail_d;
    logic [1:0]            wr_cnt_q, wr_cnt_d;
    logic [DATA_WIDTH-1:0] fifo_q [RD_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_d [RD_DEPTH];
    logic [DATA_WIDTH-1:0] push_data;
    logic                  rd_hs, rd_pop, wr_hs, wr_ack;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(RD_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Count the in-flight read as occupied so its data always has a slot at push time.
    assign rd_req_r_rdy   = rst && (({1'b0, rd_cnt_q} + {2'b00, inflight_q}) < 3'(RD_DEPTH));
    assign rd_hs          = rd_req_r_vld && rd_req_r_rdy;
    assign rd_resp_s_vld  = rst && (rd_cnt_q != 2'd0);
    assign rd_pop         = rd_resp_s_vld && rd_resp_s_rdy;
    assign rd_resp_s_data = rst ? fifo_q[rd_head_q] : '0;

    assign wr_req_r_rdy   = rst && (wr_cnt_q != 2'd3);
    assign wr_hs          = wr_req_r_vld && wr_req_r_rdy;
    assign wr_resp_s_vld  = rst && (wr_cnt_q != 2'd0);
    assign wr_ack         = wr_resp_s_vld && wr_resp_s_rdy;

    assign ram_rd_en   = rd_hs;
    assign ram_rd_addr = rst ? rd_addr : '0;
    assign ram_rd_mask = rst ? rd_mask : '0;
    assign ram_wr_en   = wr_hs;
    assign ram_wr_addr = rst ? wr_addr : '0;
    assign ram_wr_data = rst ? wr_data : '0;
    assign ram_wr_mask = rst ? wr_mask : '0;

`ifdef RAM_RESP_ADAPTER_RD_MASK_ZERO_EN
    logic [NUM_PARTITIONS-1:0] rd_mask_q, rd_mask_d;
    logic [DATA_WIDTH-1:0]     keep_bits;

    for (genvar p = 0; p < NUM_PARTITIONS; p++) begin : g_keep
        assign keep_bits[p*PW +: PW] = {PW{rd_mask_q[p]}};
    end

    always_comb begin
        rd_mask_d = rd_mask_q;
        if (rd_hs) rd_mask_d = rd_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst) rd_mask_q <= '0;
        else      rd_mask_q <= rd_mask_d;
    end

    assign push_data = ram_rd_data & keep_bits;
`else
    assign push_data = ram_rd_data;
`endif

    always_comb begin
        inflight_d = rd_hs;
        rd_head_d  = rd_head_q;
        rd_tail_d  = rd_tail_q;
        rd_cnt_d   = rd_cnt_q;
        fifo_d     = fifo_q;
        if (inflight_q) begin
            fifo_d[rd_tail_q] = push_data;
            rd_tail_d         = ptr_inc(rd_tail_q);
        end
        if (rd_pop) rd_head_d = ptr_inc(rd_head_q);
        case ({inflight_q, rd_pop})
            2'b10:   rd_cnt_d = rd_cnt_q + 2'd1;
            2'b01:   rd_cnt_d = rd_cnt_q - 2'd1;
            default: rd_cnt_d = rd_cnt_q;
        endcase
    end

    always_comb begin
        case ({wr_hs, wr_ack})
            2'b10:   wr_cnt_d = wr_cnt_q + 2'd1;
            2'b01:   wr_cnt_d = wr_cnt_q - 2'd1;
            default: wr_cnt_d = wr_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            rd_cnt_q   <= '0;
            rd_head_q  <= '0;
            rd_tail_q  <= '0;
            wr_cnt_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_head_q  <= rd_head_d;
            rd_tail_q  <= rd_tail_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    // Storage needs no reset: entries are only observable once counted.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_ram_resp_adapter.sv
// Scoreboard bench for ram_resp_adapter: behavioural RAM, array reference model, decoupled monitor.
module tb_ram_resp_adapter;
    localparam int DW = 64;
    localparam int SIZE = 1024;
    localparam int AW = 10;
    localparam int NP = 64;
    localparam int PW = DW / NP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [AW+NP-1:0]  rd_req_r_data;
    logic              rd_req_r_vld, rd_req_r_rdy;
    logic [DW-1:0]     rd_resp_s_data;
    logic              rd_resp_s_vld, rd_resp_s_rdy;
    logic [AW+DW+NP-1:0] wr_req_r_data;
    logic              wr_req_r_vld, wr_req_r_rdy;
    logic              wr_resp_s_vld, wr_resp_s_rdy;
    logic [AW-1:0]     ram_rd_addr, ram_wr_addr;
    logic [NP-1:0]     ram_rd_mask, ram_wr_mask;
    logic              ram_rd_en, ram_wr_en;
    logic [DW-1:0]     ram_rd_data, ram_wr_data;

    ram_resp_adapter #(.DATA_WIDTH(DW), .SIZE(SIZE), .ADDR_WIDTH(AW), .NUM_PARTITIONS(NP)) dut (
        .clk(clk), .rst(rst),
        .rd_req_r_data(rd_req_r_data), .rd_req_r_vld(rd_req_r_vld), .rd_req_r_rdy(rd_req_r_rdy),
        .rd_resp_s_data(rd_resp_s_data), .rd_resp_s_vld(rd_resp_s_vld), .rd_resp_s_rdy(rd_resp_s_rdy),
        .wr_req_r_data(wr_req_r_data), .wr_req_r_vld(wr_req_r_vld), .wr_req_r_rdy(wr_req_r_rdy),
        .wr_resp_s_vld(wr_resp_s_vld), .wr_resp_s_rdy(wr_resp_s_rdy),
        .ram_rd_addr(ram_rd_addr), .ram_rd_mask(ram_rd_mask), .ram_rd_en(ram_rd_en),
        .ram_rd_data(ram_rd_data),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_wr_mask(ram_wr_mask),
        .ram_wr_en(ram_wr_en)
    );

    // Behavioural 1R1W RAM: registered read, read-before-write on collision.
    logic [DW-1:0] ram_mem [SIZE];
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
        if (ram_wr_en)
            for (int i = 0; i < NP; i++)
                if (ram_wr_mask[i]) ram_mem[ram_wr_addr][i*PW +: PW] <= ram_wr_data[i*PW +: PW];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [DW-1:0] data; int cyc; bit lat; } rd_exp_t;
    typedef struct { int cyc; bit lat; } wr_exp_t;
    rd_exp_t rdq[$];
    wr_exp_t wrq[$];

    logic [DW-1:0] ref_mem [SIZE];
    int n_chk = 0, n_fail = 0;
    bit lat_chk = 0, stream_mode = 0, last_rd_hs = 0;
    logic [AW-1:0] rd_a_cur, wr_a_cur;
    logic [NP-1:0] rd_m_cur, wr_m_cur;
    logic [DW-1:0] wr_d_cur;

    function automatic logic [DW-1:0] expand(input logic [NP-1:0] m);
        logic [DW-1:0] r;
        for (int i = 0; i < NP; i++) r[i*PW +: PW] = {PW{m[i]}};
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response handshakes.
    initial forever begin
        @(negedge clk);
        #4;
        if (rst) begin
            if (rd_resp_s_vld && rd_resp_s_rdy) begin
                if (rdq.size() == 0) check("rd_unexpected_resp", 1, 0);
                else begin
                    rd_exp_t e;
                    e = rdq.pop_front();
                    check("rd_data", rd_resp_s_data, e.data);
                    if (e.lat) check("rd_latency", cyc, e.cyc + 2);
                end
            end
            if (wr_resp_s_vld && wr_resp_s_rdy) begin
                if (wrq.size() == 0) check("wr_unexpected_ack", 1, 0);
                else begin
                    wr_exp_t w;
                    w = wrq.pop_front();
                    if (w.lat) check("wr_latency", cyc, w.cyc + 1);
                end
            end
        end
    end

    task automatic set_rd(input logic [AW-1:0] a, input logic [NP-1:0] m, input logic v);
        rd_a_cur = a; rd_m_cur = m; rd_req_r_data = {a, m}; rd_req_r_vld = v;
    endtask

    task automatic set_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NP-1:0] m,
                          input logic v);
        wr_a_cur = a; wr_d_cur = d; wr_m_cur = m; wr_req_r_data = {a, d, m}; wr_req_r_vld = v;
    endtask

    // One cycle: sample handshakes just before the edge and update the reference model.
    task automatic step();
        #4;
        last_rd_hs = 0;
        if (rst) begin
            if (stream_mode) begin
                check("stream_rd_rdy", rd_req_r_rdy, 1);
                check("stream_wr_rdy", wr_req_r_rdy, 1);
            end
            if (rd_req_r_vld && rd_req_r_rdy) begin
                rd_exp_t e;
`ifdef RAM_RESP_ADAPTER_RD_MASK_ZERO_EN
                e.data = ref_mem[rd_a_cur] & expand(rd_m_cur);
`else
                e.data = ref_mem[rd_a_cur];
`endif
                e.cyc = cyc; e.lat = lat_chk;
                rdq.push_back(e);
                last_rd_hs = 1;
            end
            if (wr_req_r_vld && wr_req_r_rdy) begin
                wr_exp_t w;
                ref_mem[wr_a_cur] = (ref_mem[wr_a_cur] & ~expand(wr_m_cur)) | (wr_d_cur & expand(wr_m_cur));
                w.cyc = cyc; w.lat = lat_chk;
                wrq.push_back(w);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rd_req_r_vld = 0; wr_req_r_vld = 0;
        repeat (n) step();
    endtask

    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < SIZE; i++) begin
            v = {$urandom, $urandom};
            ram_mem[i] <= v;
            ref_mem[i] = v;
        end
        rst = 0;
        rd_resp_s_rdy = 0; wr_resp_s_rdy = 0;
        set_rd('0, '0, 0);
        set_wr('0, '0, '0, 0);
        @(negedge clk);

        // Reset held with requests pending: every output must be zero.
        set_rd(10'd3, '1, 1);
        set_wr(10'd4, {$urandom, $urandom}, '1, 1);
        rd_resp_s_rdy = 1; wr_resp_s_rdy = 1;
        repeat (3) begin
            #4;
            check("reset_outputs_zero", |{rd_req_r_rdy, rd_resp_s_vld, rd_resp_s_data, wr_req_r_rdy,
                  wr_resp_s_vld, ram_rd_addr, ram_rd_mask, ram_rd_en, ram_wr_addr, ram_wr_data,
                  ram_wr_mask, ram_wr_en}, 0);
            @(negedge clk);
        end
        rst = 1;
        rd_req_r_vld = 0; wr_req_r_vld = 0;
        #4;
        check("post_reset_rd_rdy", rd_req_r_rdy, 1);
        check("post_reset_wr_rdy", wr_req_r_rdy, 1);
        check("post_reset_rd_vld", rd_resp_s_vld, 0);
        check("post_reset_wr_vld", wr_resp_s_vld, 0);
        @(negedge clk);

        // Write then read back address 5.
        lat_chk = 1;
        set_wr(10'd5, 64'h0123_4567_89AB_CDEF, '1, 1);
        step();
        wr_req_r_vld = 0;
        set_rd(10'd5, '1, 1);
        step();
        idle(4);

        // Back-pressure: only three reads fit while responses are stalled.
        begin
            int next_a;
            lat_chk = 0;
            rd_resp_s_rdy = 0;
            next_a = 0;
            repeat (6) begin
                set_rd(AW'(next_a), '1, 1);
                step();
                if (last_rd_hs) next_a++;
            end
            check("bp_accept_count", next_a, 3);
            check("bp_rd_rdy_low", rd_req_r_rdy, 0);
            rd_resp_s_rdy = 1;
            for (int k = 0; k < 20 && next_a < 5; k++) begin
                set_rd(AW'(next_a), '1, 1);
                step();
                if (last_rd_hs) next_a++;
            end
            check("bp_all_accepted", next_a, 5);
            idle(6);
            check("bp_drained", rdq.size(), 0);
        end

        // Partial masks on reads and writes.
        lat_chk = 1;
        set_wr(10'd9, {$urandom, $urandom}, '1, 1);
        step();
        wr_req_r_vld = 0;
        set_rd(10'd9, 64'h1, 1);
        step();
        set_wr(10'd10, {$urandom, $urandom}, {$urandom, $urandom}, 1);
        rd_req_r_vld = 0;
        step();
        wr_req_r_vld = 0;
        set_rd(10'd10, '1, 1);
        step();
        set_rd(10'd10, 64'hF0F0_0000_FFFF_0001, 1);
        step();
        idle(4);

        // Same-address read and write in one cycle: read sees the old word.
        set_wr(10'd7, 64'hAA, '1, 1);
        step();
        wr_req_r_vld = 0;
        idle(1);
        set_rd(10'd7, '1, 1);
        set_wr(10'd7, 64'hBB, '1, 1);
        step();
        wr_req_r_vld = 0;
        set_rd(10'd7, '1, 1);
        step();
        idle(4);

        // Streaming: one read and one write per cycle on both paths.
        stream_mode = 1;
        repeat (16) begin
            set_rd(AW'($urandom_range(0, 31)), '1, 1);
            set_wr(AW'($urandom_range(0, 31)), {$urandom, $urandom}, {$urandom, $urandom}, 1);
            step();
        end
        stream_mode = 0;
        idle(4);

        // Random traffic with random back-pressure on a small address window.
        lat_chk = 0;
        repeat (200) begin
            set_rd(AW'($urandom_range(0, 15)), {$urandom, $urandom}, 1'($urandom));
            set_wr(AW'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            rd_resp_s_rdy = 1'($urandom_range(0, 3) != 0);
            wr_resp_s_rdy = 1'($urandom_range(0, 3) != 0);
            step();
        end
        rd_resp_s_rdy = 1; wr_resp_s_rdy = 1;
        for (int k = 0; k < 50 && (rdq.size() != 0 || wrq.size() != 0); k++) idle(1);
        check("rand_rd_drained", rdq.size(), 0);
        check("rand_wr_drained", wrq.size(), 0);

        // Reset mid-operation discards queued responses and acks.
        rd_resp_s_rdy = 0; wr_resp_s_rdy = 0;
        repeat (2) begin
            set_rd(AW'($urandom_range(0, 15)), '1, 1);
            set_wr(AW'($urandom_range(0, 15)), {$urandom, $urandom}, '1, 1);
            step();
        end
        set_rd(10'd1, '1, 1);
        step();
        rst = 0;
        idle(2);
        rdq.delete();
        wrq.delete();
        rst = 1;
        rd_resp_s_rdy = 1; wr_resp_s_rdy = 1;
        repeat (6) begin
            #4;
            check("flush_rd_vld", rd_resp_s_vld, 0);
            check("flush_wr_vld", wr_resp_s_vld, 0);
            @(negedge clk);
        end

        // Memory still coherent after the flush.
        lat_chk = 1;
        set_rd(10'd7, '1, 1);
        step();
        idle(4);
        check("final_rd_drained", rdq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
